// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one sram-like memory port between the instruction
// fetch requester and the data access requester. One transaction is in flight
// at a time; data requests win ties unless a waiting fetch has already seen
// DATA_RUN_MAX data grants in a row, in which case the fetch goes next.
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DATA_RUN_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,

  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INST,
    OWN_DATA
  } owner_t;

  localparam int RUN_W = $clog2(DATA_RUN_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX_C = RUN_W'(DATA_RUN_MAX);

  state_t            state;
  state_t            state_nx;
  owner_t            owner;
  owner_t            owner_nx;
  logic [RUN_W-1:0]  run_cnt;
  logic [RUN_W-1:0]  run_cnt_nx;
  logic              grant_inst;
  logic              grant_data;
  logic              addr_acc;
  logic              data_acc;
  logic [DATA_W-1:0] inst_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;

  // Next-state logic: arbitration in IDLE, handshake tracking in REQ/RESP.
  always_comb begin
    state_nx   = state;
    owner_nx   = owner;
    run_cnt_nx = run_cnt;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    addr_acc   = 1'b0;
    data_acc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!inst_req) begin
          run_cnt_nx = '0;
        end
        if (data_req && !(inst_req && (run_cnt == RUN_MAX_C))) begin
          grant_data = 1'b1;
          owner_nx   = OWN_DATA;
          state_nx   = S_REQ;
          if (inst_req && (run_cnt != RUN_MAX_C)) begin
            run_cnt_nx = run_cnt + 1'b1;
          end
        end else if (inst_req) begin
          grant_inst = 1'b1;
          owner_nx   = OWN_INST;
          state_nx   = S_REQ;
          run_cnt_nx = '0;
        end
      end
      S_REQ: begin
        if (bus_addr_ok) begin
          addr_acc = 1'b1;
          if (bus_data_ok) begin
            data_acc = 1'b1;
            state_nx = S_IDLE;
            owner_nx = OWN_NONE;
          end else begin
            state_nx = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bus_data_ok) begin
          data_acc = 1'b1;
          state_nx = S_IDLE;
          owner_nx = OWN_NONE;
        end
      end
      default: begin
        state_nx = S_IDLE;
        owner_nx = OWN_NONE;
      end
    endcase
  end

  // State, owner and starvation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      owner   <= OWN_NONE;
      run_cnt <= '0;
    end else begin
      state   <= state_nx;
      owner   <= owner_nx;
      run_cnt <= run_cnt_nx;
    end
  end

  // Bus request registers: fields latched at grant, bus_req dropped after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (grant_data) begin
      bus_req   <= 1'b1;
      bus_wr    <= data_wr;
      bus_size  <= data_size;
      bus_addr  <= data_addr;
      bus_wdata <= data_wdata;
    end else if (grant_inst) begin
      bus_req   <= 1'b1;
      bus_wr    <= 1'b0;
      bus_size  <= 2'd2;
      bus_addr  <= inst_addr;
      bus_wdata <= '0;
    end else if (addr_acc) begin
      bus_req   <= 1'b0;
    end
  end

  // Read data holding registers, updated only on the owner's load completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      if (inst_data_ok) begin
        inst_rdata_q <= bus_rdata;
      end
      if (data_data_ok && !bus_wr) begin
        data_rdata_q <= bus_rdata;
      end
    end
  end

  // Pulses go only to the current owner and are suppressed while reset is held.
  assign inst_addr_ok = !rst && addr_acc && (owner == OWN_INST);
  assign inst_data_ok = !rst && data_acc && (owner == OWN_INST);
  assign data_addr_ok = !rst && addr_acc && (owner == OWN_DATA);
  assign data_data_ok = !rst && data_acc && (owner == OWN_DATA);

  // Completion data is passed straight through in the pulse cycle, then held.
  assign inst_rdata = inst_data_ok ? bus_rdata : inst_rdata_q;
  assign data_rdata = (data_data_ok && !bus_wr) ? bus_rdata : data_rdata_q;

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: randomized requesters and bridge drive the arbiter; a
// reference model predicts grants from the arbitration rules and pushes
// expected bus transactions into a scoreboard queue that the monitor pops.
module tb_sram_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int DATA_RUN_MAX = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              inst_req = 1'b0;
  logic [ADDR_W-1:0] inst_addr = '0;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req = 1'b0;
  logic              data_wr = 1'b0;
  logic [1:0]        data_size = 2'd0;
  logic [ADDR_W-1:0] data_addr = '0;
  logic [DATA_W-1:0] data_wdata = '0;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              bus_req;
  logic              bus_wr;
  logic [1:0]        bus_size;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok = 1'b0;
  logic              bus_data_ok = 1'b0;
  logic [DATA_W-1:0] bus_rdata = '0;
  logic              busy;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .DATA_RUN_MAX(DATA_RUN_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata),
    .busy        (busy)
  );

  typedef struct {
    bit                is_data;
    bit                wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  txn_t expq[$];

  int errors = 0;
  int checks = 0;

  int inst_rate  = 50;
  int data_rate  = 50;
  bit hold_resp  = 1'b0;
  bit inst_taken = 1'b0;
  bit data_taken = 1'b0;
  int bstate     = 0;
  int addr_wait  = 0;
  int data_wait  = 0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, required);
    end
  endtask

  task automatic sample_handshake();
    inst_taken = inst_req && inst_addr_ok;
    data_taken = data_req && data_addr_ok;
  endtask

  // Bridge model: random accept latency 0..2, random response latency 0..2,
  // plus stray data_ok pulses whenever no response is legitimately due.
  task automatic drive_bridge();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = $urandom();
    if (bstate == 0 && bus_req) begin
      bstate    = 1;
      addr_wait = int'($urandom_range(2));
    end
    if (bstate == 1) begin
      if (addr_wait == 0) begin
        bus_addr_ok = 1'b1;
        data_wait   = int'($urandom_range(2));
        if (data_wait == 0 && !hold_resp) begin
          bus_data_ok = 1'b1;
          bstate      = 0;
        end else begin
          bstate = 2;
          if (data_wait > 0) data_wait--;
        end
      end else begin
        addr_wait--;
        if ($urandom_range(9) == 0) bus_data_ok = 1'b1;
      end
    end else if (bstate == 2) begin
      if (data_wait == 0 && !hold_resp) begin
        bus_data_ok = 1'b1;
        bstate      = 0;
      end else if (data_wait > 0) begin
        data_wait--;
      end
    end else if ($urandom_range(9) == 0) begin
      bus_data_ok = 1'b1;
    end
  endtask

  // One cycle of stimulus: requesters retire accepted requests and maybe
  // raise new ones, then the bridge reacts to the current bus request.
  task automatic apply_stimulus();
    @(negedge clk);
    if (inst_taken) inst_req = 1'b0;
    if (data_taken) data_req = 1'b0;
    if (!inst_req && int'($urandom_range(99)) < inst_rate) begin
      inst_req  = 1'b1;
      inst_addr = $urandom() & 32'hFFFF_FFFC;
    end
    if (!data_req && int'($urandom_range(99)) < data_rate) begin
      data_req   = 1'b1;
      data_wr    = 1'($urandom_range(1));
      data_size  = 2'($urandom_range(2));
      data_addr  = $urandom();
      data_wdata = $urandom();
    end
    drive_bridge();
    #1 sample_handshake();
  endtask

  task automatic drain();
    int quiet;
    quiet = 0;
    inst_rate = 0;
    data_rate = 0;
    for (int i = 0; i < 200 && quiet < 3; i++) begin
      apply_stimulus();
      if (!inst_req && !data_req && bstate == 0 && !bus_req) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 3) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got traffic still pending, want idle bus within 200 cycles");
    end
  endtask

  // Stimulus sequence: reset, random mix, starvation pressure, mid-transaction reset.
  initial begin : driver
    bit got;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 sample_handshake();

    inst_rate = 50; data_rate = 50;
    repeat (1500) apply_stimulus();

    inst_rate = 100; data_rate = 100;
    repeat (600) apply_stimulus();

    inst_rate = 30; data_rate = 80;
    repeat (500) apply_stimulus();

    drain();

    hold_resp = 1'b1;
    data_rate = 100;
    apply_stimulus();
    data_rate = 0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      apply_stimulus();
      if (bstate == 2) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("[TB] FAIL resp_wait_timeout: got no accepted data request, want one within 50 cycles");
    end

    @(negedge clk);
    rst         = 1'b1;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bstate      = 0;
    #1 sample_handshake();
    @(negedge clk);
    rst         = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'h5A5A_1234;
    hold_resp   = 1'b0;
    #1 sample_handshake();

    inst_rate = 50; data_rate = 50;
    repeat (200) apply_stimulus();
    drain();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Reference model and monitor: predicts grants from the arbitration rules
  // using only the stimulus, pushes expected transactions, and pops them when
  // the DUT raises bus_req; pulses and read data are checked every cycle.
  initial begin : monitor
    int                phase;
    int                next_phase;
    int                run;
    bit                after_rst;
    bit                prev_bus_req;
    bit                m_is_data;
    bit                m_wr;
    bit                fetch_wins;
    logic [3:0]        exp_ok;
    logic [DATA_W-1:0] held_i;
    logic [DATA_W-1:0] held_d;
    logic [DATA_W-1:0] exp_i;
    logic [DATA_W-1:0] exp_d;
    txn_t              t;
    phase = 0; run = 0; after_rst = 1'b0; prev_bus_req = 1'b0;
    m_is_data = 1'b0; m_wr = 1'b0; held_i = '0; held_d = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        check_output("ok_during_reset",
                     64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 64'(0));
        phase = 0; run = 0; expq.delete();
        held_i = '0; held_d = '0;
        after_rst = 1'b1; prev_bus_req = 1'b0;
        continue;
      end

      if (after_rst) begin
        check_output("reset_bus_req",    64'(bus_req),    64'(0));
        check_output("reset_bus_wr",     64'(bus_wr),     64'(0));
        check_output("reset_bus_size",   64'(bus_size),   64'(0));
        check_output("reset_bus_addr",   64'(bus_addr),   64'(0));
        check_output("reset_bus_wdata",  64'(bus_wdata),  64'(0));
        check_output("reset_busy",       64'(busy),       64'(0));
        check_output("reset_inst_rdata", 64'(inst_rdata), 64'(0));
        check_output("reset_data_rdata", 64'(data_rdata), 64'(0));
        after_rst = 1'b0;
      end

      if (bus_req && !prev_bus_req) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_bus_req: got bus_req=1, want 0 (no grant predicted)");
        end else begin
          t = expq.pop_front();
          check_output("grant_bus_wr",   64'(bus_wr),   64'(t.wr));
          check_output("grant_bus_size", 64'(bus_size), 64'(t.size));
          check_output("grant_bus_addr", 64'(bus_addr), 64'(t.addr));
          if (t.is_data) check_output("grant_bus_wdata", 64'(bus_wdata), 64'(t.wdata));
        end
      end

      exp_ok     = 4'b0000;
      next_phase = phase;
      case (phase)
        0: begin
          check_output("idle_busy",    64'(busy),    64'(0));
          check_output("idle_bus_req", 64'(bus_req), 64'(0));
          if (inst_req || data_req) begin
            fetch_wins = inst_req && (!data_req || run >= DATA_RUN_MAX);
            if (fetch_wins) begin
              t = '{is_data: 1'b0, wr: 1'b0, size: 2'd2, addr: inst_addr, wdata: '0};
              run = 0;
            end else begin
              t = '{is_data: 1'b1, wr: data_wr, size: data_size, addr: data_addr,
                    wdata: data_wdata};
              run = inst_req ? ((run < DATA_RUN_MAX) ? run + 1 : run) : 0;
            end
            expq.push_back(t);
            m_is_data  = t.is_data;
            m_wr       = t.wr;
            next_phase = 1;
          end else begin
            run = 0;
          end
        end
        1: begin
          check_output("req_busy",    64'(busy),    64'(1));
          check_output("req_bus_req", 64'(bus_req), 64'(1));
          if (bus_addr_ok) begin
            exp_ok     = m_is_data ? 4'b0010 : 4'b1000;
            next_phase = 2;
            if (bus_data_ok) begin
              exp_ok     = m_is_data ? 4'b0011 : 4'b1100;
              next_phase = 0;
            end
          end
        end
        default: begin
          check_output("resp_busy",    64'(busy),    64'(1));
          check_output("resp_bus_req", 64'(bus_req), 64'(0));
          if (bus_data_ok) begin
            exp_ok     = m_is_data ? 4'b0001 : 4'b0100;
            next_phase = 0;
          end
        end
      endcase

      check_output("ok_pulses",
                   64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 64'(exp_ok));

      exp_i = exp_ok[2] ? bus_rdata : held_i;
      exp_d = (exp_ok[0] && !m_wr) ? bus_rdata : held_d;
      check_output("inst_rdata", 64'(inst_rdata), 64'(exp_i));
      check_output("data_rdata", 64'(data_rdata), 64'(exp_d));
      held_i = exp_i;
      held_d = exp_d;

      phase        = next_phase;
      prev_bus_req = bus_req;
    end
  end

endmodule
